// File: rtl/park_occupancy_tracker_if.sv
// park_occupancy_tracker_if: entry/exit requests and occupancy status of the parking tracker.
interface park_occupancy_tracker_if;
   logic       entry;
   logic [2:0] park_number;
   logic       exit;
   logic [2:0] exit_slot;
   logic [7:0] parking_capacity;
   logic       gate_open;
   logic [2:0] assigned_slot;
   logic [3:0] occupied_count;
   logic       full;
   logic       err;
   modport master (
      output entry, park_number, exit, exit_slot,
      input  parking_capacity, gate_open, assigned_slot, occupied_count, full, err
   );
   modport slave (
      input  entry, park_number, exit, exit_slot,
      output parking_capacity, gate_open, assigned_slot, occupied_count, full, err
   );
endinterface

// File: rtl/park_occupancy_tracker.sv
// park_occupancy_tracker: admits cars on entry edges, tracks slot bitmap, times the gate.
// Define PARK_EXIT_CHECK_EN to flag exits on free slots through err.
module park_occupancy_tracker #(
   parameter int GATE_CYCLES = 4
) (
   input logic clk,
   input logic reset,
   park_occupancy_tracker_if.slave p
);
   typedef enum logic [1:0] {IDLE, ASSIGN, OPEN} state_t;
   state_t     state, state_nx;
   logic       entry_q;
   logic [3:0] timer;
   logic       req;
   logic       exit_ok;
   logic [7:0] cap_nx;
   logic [3:0] cnt_nx;
   assign req = p.entry & ~entry_q;
   assign p.full = p.occupied_count == 4'd8;
   assign p.gate_open = state == OPEN;
   always_comb begin
      state_nx = state == IDLE   ? ((req && !p.full) ? ASSIGN : IDLE) :
                 state == ASSIGN ? OPEN :
                 (timer == 4'd1 ? IDLE : OPEN);
      // exits on free slots never touch the bitmap; the ASSIGN set is applied last so it wins
      exit_ok = p.exit & p.parking_capacity[p.exit_slot];
      cap_nx = (p.parking_capacity & ~({7'd0, exit_ok} << p.exit_slot))
             | ({7'd0, state == ASSIGN} << p.park_number);
      cnt_nx = 4'($countones(cap_nx));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         entry_q            <= 1'b0;
         timer              <= 4'd0;
         p.parking_capacity <= 8'h00;
         p.occupied_count   <= 4'd0;
         p.assigned_slot    <= 3'd0;
      end else begin
         state              <= state_nx;
         entry_q            <= p.entry;
         timer              <= state == ASSIGN ? 4'(GATE_CYCLES) : state == OPEN ? timer - 4'd1 : timer;
         p.parking_capacity <= cap_nx;
         p.occupied_count   <= cnt_nx;
         if (state == ASSIGN) p.assigned_slot <= p.park_number;
      end
   end
`ifdef PARK_EXIT_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) p.err <= 1'b0;
      else p.err <= p.exit & ~p.parking_capacity[p.exit_slot];
   end
`else
   assign p.err = 1'b0;
`endif
endmodule

// File: tb/tb_park_occupancy_tracker.sv
// tb_park_occupancy_tracker: directed and random stimulus, per-cycle scoreboard against a countdown model.
module tb_park_occupancy_tracker;
   localparam int G = 4;
   typedef struct {
      logic [7:0] cap;
      logic       gate;
      logic [2:0] asg;
      logic [3:0] cnt;
      logic       full;
      logic       err;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   park_occupancy_tracker_if bus();
   park_occupancy_tracker #(.GATE_CYCLES(G)) dut (.clk(clk), .reset(reset), .p(bus.slave));
   always #5 clk = ~clk;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   logic [7:0] m_cap = 8'h00;
   int         m_left = 0;
   logic [2:0] m_asg = 3'd0;
   logic       m_prev = 1'b0;
   logic       m_err = 1'b0;
   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", n, a, e);
      end
   endtask
   task automatic step(input logic e, input logic [2:0] pn, input logic x, input logic [2:0] xs, input logic r);
      exp_t t;
      logic set, ok;
      @(negedge clk);
      reset = r;
      bus.entry = e;
      bus.park_number = pn;
      bus.exit = x;
      bus.exit_slot = xs;
      if (r) begin
         m_cap = 8'h00; m_left = 0; m_asg = 3'd0; m_prev = 1'b0; m_err = 1'b0;
      end else begin
         set = m_left == G + 1;
         ok = x && m_cap[xs];
`ifdef PARK_EXIT_CHECK_EN
         m_err = x && !m_cap[xs];
`else
         m_err = 1'b0;
`endif
         if (set) m_left = G;
         else if (m_left > 0) m_left = m_left - 1;
         else if (e && !m_prev && $countones(m_cap) < 8) m_left = G + 1;
         if (ok) m_cap[xs] = 1'b0;
         if (set) begin
            m_cap[pn] = 1'b1;
            m_asg = pn;
         end
         m_prev = e;
      end
      t.cap = m_cap;
      t.gate = m_left >= 1 && m_left <= G;
      t.asg = m_asg;
      t.cnt = 4'($countones(m_cap));
      t.full = $countones(m_cap) == 8;
      t.err = m_err;
      @(posedge clk);
      #1 q.push_back(t);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
   endtask
   task automatic admit(input logic [2:0] pn);
      step(1'b1, pn, 1'b0, 3'd0, 1'b0);
      step(1'b0, pn, 1'b0, 3'd0, 1'b0);
      idle(G);
   endtask
   function automatic logic [2:0] pick_free();
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) if (!m_cap[3'(s + 3'(i))] && $urandom_range(0, 4) != 0) return 3'(s + 3'(i));
      return s;
   endfunction
   always @(negedge clk) begin
      exp_t t;
      if (q.size() != 0) begin
         t = q.pop_front();
         chk("parking_capacity", bus.parking_capacity, t.cap);
         chk("gate_open", {7'd0, bus.gate_open}, {7'd0, t.gate});
         chk("assigned_slot", {5'd0, bus.assigned_slot}, {5'd0, t.asg});
         chk("occupied_count", {4'd0, bus.occupied_count}, {4'd0, t.cnt});
         chk("full", {7'd0, bus.full}, {7'd0, t.full});
         chk("err", {7'd0, bus.err}, {7'd0, t.err});
      end
   end
   initial begin
      reset = 1'b1;
      bus.entry = 1'b0; bus.park_number = 3'd0; bus.exit = 1'b0; bus.exit_slot = 3'd0;
      step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      idle(1);
      // single admission to slot 3, entry held high through the gate window
      step(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
      for (int i = 0; i < G + 4; i++) step(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
      idle(2);
      // fill every slot, then a ninth request while full
      step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      for (int s = 0; s < 8; s++) admit(3'(s));
      step(1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
      idle(3);
      step(1'b0, 3'd0, 1'b1, 3'd5, 1'b0);
      idle(2);
      // exit on slot 0 in the same cycle slot 2 is assigned
      step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      admit(3'd0);
      step(1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd2, 1'b1, 3'd0, 1'b0);
      idle(G);
      // same-slot set and exit, exit on a free slot, reset mid-gate
      step(1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd2, 1'b1, 3'd2, 1'b0);
      step(1'b0, 3'd0, 1'b1, 3'd6, 1'b0);
      step(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
      step(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
      step(1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
      step(1'b1, 3'd0, 1'b0, 3'd0, 1'b1);
      step(1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
      step(1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
      idle(G + 1);
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 1)), pick_free(), $urandom_range(0, 2) == 0,
              3'($urandom_range(0, 7)), $urandom_range(0, 150) == 0);
      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/park_occupancy_tracker.md
PARK_OCCUPANCY_TRACKER -- requirements
Module: park_occupancy_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have this parameter: GATE_CYCLES, default 4, entry-gate open time in clock cycles (legal range 1..15).
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit, synchronous active-high reset.
REQ-005 Port entry SHALL be input, 1 bit, car-present level at the entry gate.
REQ-006 Port park_number SHALL be input, 3 bits, free slot index chosen by the downstream allocator from parking_capacity.
REQ-007 Port exit SHALL be input, 1 bit, single-cycle pulse marking a car leaving.
REQ-008 Port exit_slot SHALL be input, 3 bits, slot index vacated when exit=1.
REQ-009 Port parking_capacity SHALL be output, 8 bits, registered occupancy bitmap; bit i=1 means slot i is occupied; it feeds the allocator.
REQ-010 Port gate_open SHALL be output, 1 bit, entry barrier raised.
REQ-011 Port assigned_slot SHALL be output, 3 bits, slot granted to the most recent admitted car.
REQ-012 Port occupied_count SHALL be output, 4 bits, number of set bits in parking_capacity (0..8).
REQ-013 Port full SHALL be output, 1 bit, high when occupied_count == 8.
REQ-014 Port err SHALL be output, 1 bit, single-cycle exit-error pulse (see Configuration).

Function
REQ-015 An admission request SHALL be a rising edge of entry: entry=1 while the registered previous value of entry is 0.
REQ-016 The FSM SHALL have three states: IDLE, ASSIGN and OPEN.
REQ-017 In IDLE, a request with full=0 SHALL move the FSM to ASSIGN; a request with full=1 SHALL be dropped, and the FSM SHALL stay in IDLE.
REQ-018 ASSIGN SHALL last exactly one cycle, during which park_number is sampled.
REQ-019 On leaving ASSIGN: bit park_number of parking_capacity SHALL be set, assigned_slot <= park_number, occupied_count SHALL increment, the timer SHALL load GATE_CYCLES, and the FSM SHALL enter OPEN.
REQ-020 gate_open SHALL be 1 exactly while in OPEN, i.e. for GATE_CYCLES consecutive cycles, starting the cycle after ASSIGN.
REQ-021 In OPEN the timer SHALL decrement each cycle; when the timer is 1, the next state SHALL be IDLE.
REQ-022 Request edges arriving in ASSIGN or OPEN SHALL be ignored, not queued.
REQ-023 Exit SHALL be processed in every state: bit exit_slot SHALL be cleared and occupied_count SHALL decrement, subject to REQ-031/REQ-032.
REQ-024 If exit and the ASSIGN update occur in the same cycle on different slots, both SHALL apply and occupied_count SHALL be unchanged.
REQ-025 If exit and the ASSIGN update occur in the same cycle on the same slot, the set SHALL win, and occupied_count SHALL increment.
REQ-026 occupied_count SHALL never wrap: it SHALL always equal the popcount of parking_capacity.
REQ-027 full SHALL be combinational from occupied_count.

Reset
REQ-028 On reset=1 at a clock edge the block SHALL set: parking_capacity=8'h00, occupied_count=0, full=0, gate_open=0, assigned_slot=0, err=0, timer=0, FSM=IDLE, and previous-entry register=0.
REQ-029 Reset SHALL take priority over all other inputs, including mid-OPEN, where gate_open SHALL drop the cycle after reset is sampled.
REQ-030 After reset is released, entry held at 1 SHALL count as a request, because the previous-entry register is 0.

Configuration
REQ-031 With PARK_EXIT_CHECK_EN defined: an exit on a slot whose bit is 0 SHALL be ignored (no bitmap or count change), and err SHALL pulse 1 for one cycle; the same-cycle ASSIGN set on that slot counts as occupied only after the edge, so such an exit is still an error.
REQ-032 With PARK_EXIT_CHECK_EN undefined: err SHALL be tied 0, and an exit on a free slot SHALL leave the bitmap and count unchanged without flagging.

Verification
REQ-033 Reset, then entry 0->1 with park_number=3 -> ASSIGN for 1 cycle; parking_capacity=8'h08, assigned_slot=3, occupied_count=1; gate_open high for exactly 4 cycles.
REQ-034 Hold entry=1 through OPEN and back to IDLE -> no second admission; parking_capacity stays 8'h08.
REQ-035 Fill all 8 slots with park_numbers 0..7 -> parking_capacity=8'hFF, full=1; a 9th entry edge -> FSM stays IDLE, gate_open=0, no state change.
REQ-036 Start at 8'hFF, pulse exit with exit_slot=5 -> parking_capacity=8'hDF, occupied_count=7, full=0.
REQ-037 In the ASSIGN cycle with park_number=2, exit_slot=0, and starting bitmap 8'h01 -> bitmap 8'h04, count unchanged at 1.
REQ-038 With PARK_EXIT_CHECK_EN defined, exit on free slot 6 -> err=1 for one cycle and bitmap unchanged; reset asserted mid-OPEN -> all outputs at reset values on the next cycle.
